// File: rtl/neo_reset_pkg.sv
// Shared types and constants for the reset sequencer / watchdog.
package neo_reset_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2,
    BTN     = 2'd3
  } state_t;

  // Cause of the most recent reset
  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  // Width of a counter that runs 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neo_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and debounced level.
// Emits one-cycle press/lift strobes on the edge where the debounced level
// flips, so the consumer can react on that same edge.
module neo_debounce
  import neo_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic CLK_24M,
  input  logic RESET,
  input  logic btn_n,
  output logic press,
  output logic lift
);

  localparam int W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         sync1_reg;
  logic         sync2_reg;
  logic         level_reg;
  logic [W-1:0] cnt_reg;
  logic         differ;
  logic         flip;

  // The debounced level flips on the edge that completes the run of
  // DEBOUNCE_CYCLES consecutive differing samples.
  assign differ = (sync2_reg != level_reg);
  assign flip   = differ && (cnt_reg == CNT_LAST);
  assign press  = flip && !sync2_reg;
  assign lift   = flip && sync2_reg;

  // Synchronize the raw button, count stable cycles, flip the level
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (flip) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/neo_resetgen.sv
// Reset sequencer and watchdog: produces the staggered peripheral (nRESETP)
// and CPU (nRESET) resets from power-on, the front-panel button and a
// frame-based watchdog kicked by the 68K.
module neo_resetgen
  import neo_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int HOLD_CYCLES     = 2400,
  parameter int STAGGER_CYCLES  = 16,
  parameter int WD_FRAMES       = 8
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       nRESET_BTN,
  input  logic       nBITWD0,
  input  logic       FRAME_TICK,
  input  logic       WD_EN,
  output logic       nRESETP,
  output logic       nRESET,
  output logic [1:0] CAUSE,
  output logic       WD_FIRED
);

  // One counter serves both HOLD and STAGGER, sized for the longer phase
  localparam int SEQ_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int SW      = cnt_width(SEQ_MAX);
  localparam int FW      = cnt_width(WD_FRAMES);
  localparam logic [SW-1:0] HOLD_LAST  = SW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST  = SW'(STAGGER_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(WD_FRAMES - 1);

  logic          btn_press;
  logic          btn_lift;
  logic          kick_s1_reg;
  logic          kick_s2_reg;
  logic          kick_d_reg;
  logic          kick;
  logic          wd_fire;
  state_t        state_reg;
  logic [SW-1:0] seq_cnt_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          nresetp_reg;
  logic          nreset_reg;
  logic [1:0]    cause_reg;
  logic          wd_fired_reg;

  neo_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK_24M(CLK_24M),
    .RESET  (RESET),
    .btn_n  (nRESET_BTN),
    .press  (btn_press),
    .lift   (btn_lift)
  );

  // Synchronize the kick strobe and keep one extra stage for edge detection
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      kick_s1_reg <= 1'b1;
      kick_s2_reg <= 1'b1;
      kick_d_reg  <= 1'b1;
    end else begin
      kick_s1_reg <= nBITWD0;
      kick_s2_reg <= kick_s1_reg;
      kick_d_reg  <= kick_s2_reg;
    end
  end

  // Kick is the falling edge of the synchronized strobe; it only counts in RUN
  assign kick    = (state_reg == RUN) && kick_d_reg && !kick_s2_reg;
  assign wd_fire = (state_reg == RUN) && FRAME_TICK && WD_EN && !kick &&
                   (frame_cnt_reg == FRAME_LAST);

  // Sequencer FSM with hold/stagger timing, frame counter and status flags
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_reg     <= HOLD;
      seq_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      nresetp_reg   <= 1'b0;
      nreset_reg    <= 1'b0;
      cause_reg     <= CAUSE_POR;
      wd_fired_reg  <= 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          nresetp_reg <= 1'b0;
          nreset_reg  <= 1'b0;
          if (btn_press) begin
            state_reg   <= BTN;
            cause_reg   <= CAUSE_BTN;
            seq_cnt_reg <= '0;
          end else if (seq_cnt_reg == HOLD_LAST) begin
            state_reg   <= STAGGER;
            seq_cnt_reg <= '0;
            nresetp_reg <= 1'b1;
          end else begin
            seq_cnt_reg <= seq_cnt_reg + 1'b1;
          end
        end

        STAGGER: begin
          if (btn_press) begin
            state_reg   <= BTN;
            cause_reg   <= CAUSE_BTN;
            seq_cnt_reg <= '0;
            nresetp_reg <= 1'b0;
            nreset_reg  <= 1'b0;
          end else if (seq_cnt_reg == STAG_LAST) begin
            state_reg     <= RUN;
            seq_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            nreset_reg    <= 1'b1;
          end else begin
            seq_cnt_reg <= seq_cnt_reg + 1'b1;
          end
        end

        RUN: begin
          // A kick can never coincide with a fire, so this clear is safe here
          if (kick) begin
            wd_fired_reg <= 1'b0;
          end
          if (btn_press) begin
            // Button beats a same-cycle watchdog fire and leaves WD_FIRED alone
            state_reg   <= BTN;
            cause_reg   <= CAUSE_BTN;
            seq_cnt_reg <= '0;
            nresetp_reg <= 1'b0;
            nreset_reg  <= 1'b0;
          end else if (wd_fire) begin
            state_reg    <= HOLD;
            cause_reg    <= CAUSE_WDOG;
            wd_fired_reg <= 1'b1;
            seq_cnt_reg  <= '0;
            nresetp_reg  <= 1'b0;
            nreset_reg   <= 1'b0;
          end else if (kick) begin
            frame_cnt_reg <= '0;
          end else if (FRAME_TICK && WD_EN && (frame_cnt_reg != FRAME_LAST)) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end

        BTN: begin
          nresetp_reg <= 1'b0;
          nreset_reg  <= 1'b0;
          if (btn_lift) begin
            state_reg   <= HOLD;
            seq_cnt_reg <= '0;
          end
        end

        default: begin
          state_reg   <= HOLD;
          seq_cnt_reg <= '0;
          nresetp_reg <= 1'b0;
          nreset_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign nRESETP  = nresetp_reg;
  assign nRESET   = nreset_reg;
  assign CAUSE    = cause_reg;
  assign WD_FIRED = wd_fired_reg;

endmodule

// File: tb/tb_neo_resetgen.sv
// Directed bench for neo_resetgen with small parameters
// (DEBOUNCE=8, HOLD=16, STAGGER=4, WD_FRAMES=3).
module tb_neo_resetgen;
  import neo_reset_pkg::*;

  logic       CLK_24M    = 1'b0;
  logic       RESET      = 1'b1;
  logic       nRESET_BTN = 1'b1;
  logic       nBITWD0    = 1'b1;
  logic       FRAME_TICK = 1'b0;
  logic       WD_EN      = 1'b1;
  logic       nRESETP;
  logic       nRESET;
  logic [1:0] CAUSE;
  logic       WD_FIRED;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK_24M = ~CLK_24M;

  neo_resetgen #(
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (4),
    .WD_FRAMES      (3)
  ) dut (
    .CLK_24M   (CLK_24M),
    .RESET     (RESET),
    .nRESET_BTN(nRESET_BTN),
    .nBITWD0   (nBITWD0),
    .FRAME_TICK(FRAME_TICK),
    .WD_EN     (WD_EN),
    .nRESETP   (nRESETP),
    .nRESET    (nRESET),
    .CAUSE     (CAUSE),
    .WD_FIRED  (WD_FIRED)
  );

  // Count edges until each reset line rises; 0 means it never rose in the window
  task automatic measure_release(output int p_edge, output int r_edge);
    p_edge = 0;
    r_edge = 0;
    for (int e = 1; e <= 40 && r_edge == 0; e++) begin
      @(negedge CLK_24M);
      if (nRESETP === 1'b1 && p_edge == 0) p_edge = e;
      if (nRESET === 1'b1 && r_edge == 0) r_edge = e;
    end
    $display("release measured: nRESETP edge %0d, nRESET edge %0d", p_edge, r_edge);
  endtask

  // One-cycle frame pulse, started and ended on falling edges
  task automatic frame_tick();
    FRAME_TICK = 1'b1;
    @(negedge CLK_24M);
    FRAME_TICK = 1'b0;
  endtask

  // Low pulse on the kick strobe, long enough to pass the synchronizer
  task automatic kick_pulse();
    nBITWD0 = 1'b0;
    repeat (3) @(negedge CLK_24M);
    nBITWD0 = 1'b1;
    repeat (3) @(negedge CLK_24M);
  endtask

  task automatic test_reset();
    int p, r;
    repeat (5) @(negedge CLK_24M);
    n_checks++;
    if ({nRESETP, nRESET, CAUSE, WD_FIRED} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_values: got %b required 00000", {nRESETP, nRESET, CAUSE, WD_FIRED});
    end
    RESET = 1'b0;
    measure_release(p, r);
    n_checks++;
    if (p !== 16) begin n_fail++; $display("FAIL por_nresetp_edge: got %0d required 16", p); end
    n_checks++;
    if (r !== 20) begin n_fail++; $display("FAIL por_nreset_edge: got %0d required 20", r); end
    n_checks++;
    if ({CAUSE, WD_FIRED} !== 3'b000) begin
      n_fail++;
      $display("FAIL por_status: got %b required 000", {CAUSE, WD_FIRED});
    end
  endtask

  task automatic test_watchdog();
    int p, r;
    frame_tick();
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL wd_before_fire: got %b required 11", {nRESETP, nRESET});
    end
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET, CAUSE, WD_FIRED} !== 5'b00101) begin
      n_fail++;
      $display("FAIL wd_fire: got %b required 00101", {nRESETP, nRESET, CAUSE, WD_FIRED});
    end
    // A kick arriving while in HOLD must not clear the sticky flag
    nBITWD0 = 1'b0;
    measure_release(p, r);
    n_checks++;
    if (p !== 16 || r !== 20) begin
      n_fail++;
      $display("FAIL wd_release_edges: got %0d/%0d required 16/20", p, r);
    end
    nBITWD0 = 1'b1;
    repeat (4) @(negedge CLK_24M);
    n_checks++;
    if (WD_FIRED !== 1'b1) begin n_fail++; $display("FAIL wd_flag_kept: got %b required 1", WD_FIRED); end
    // Kick in RUN clears the flag on the 3rd edge after the falling edge
    nBITWD0 = 1'b0;
    repeat (2) @(negedge CLK_24M);
    n_checks++;
    if (WD_FIRED !== 1'b1) begin n_fail++; $display("FAIL kick_latency_early: got %b required 1", WD_FIRED); end
    @(negedge CLK_24M);
    n_checks++;
    if (WD_FIRED !== 1'b0) begin n_fail++; $display("FAIL kick_clears_flag: got %b required 0", WD_FIRED); end
    nBITWD0 = 1'b1;
    repeat (3) @(negedge CLK_24M);
  endtask

  task automatic test_kick();
    int p, r;
    for (int i = 0; i < 20; i++) begin
      frame_tick();
      repeat (2) @(negedge CLK_24M);
      kick_pulse();
      n_checks++;
      if ({nRESETP, nRESET} !== 2'b11) begin
        n_fail++;
        $display("FAIL kick_loop_%0d: got %b required 11", i, {nRESETP, nRESET});
      end
    end
    $display("kick loop: 20 ticks with kicks completed");
    frame_tick();
    frame_tick();
    // Kick edge-detect pulse lands on the same edge as the 3rd tick
    nBITWD0 = 1'b0;
    repeat (2) @(negedge CLK_24M);
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL kick_tick_same_cycle: got %b required 11", {nRESETP, nRESET});
    end
    nBITWD0 = 1'b1;
    repeat (3) @(negedge CLK_24M);
    frame_tick();
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL kick_count_zero: got %b required 11", {nRESETP, nRESET});
    end
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET, CAUSE} !== 4'b0010) begin
      n_fail++;
      $display("FAIL kick_then_fire: got %b required 0010", {nRESETP, nRESET, CAUSE});
    end
    measure_release(p, r);
    n_checks++;
    if (p !== 16 || r !== 20) begin
      n_fail++;
      $display("FAIL kick_release_edges: got %0d/%0d required 16/20", p, r);
    end
  endtask

  task automatic test_wd_enable();
    int p, r;
    frame_tick();
    WD_EN = 1'b0;
    for (int i = 0; i < 10; i++) frame_tick();
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL wden_frozen: got %b required 11", {nRESETP, nRESET});
    end
    WD_EN = 1'b1;
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL wden_resume_2: got %b required 11", {nRESETP, nRESET});
    end
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET, CAUSE} !== 4'b0010) begin
      n_fail++;
      $display("FAIL wden_resume_fire: got %b required 0010", {nRESETP, nRESET, CAUSE});
    end
    measure_release(p, r);
    n_checks++;
    if (p !== 16 || r !== 20) begin
      n_fail++;
      $display("FAIL wden_release_edges: got %0d/%0d required 16/20", p, r);
    end
  endtask

  task automatic test_button_bounce();
    int p, r;
    for (int i = 0; i < 10; i++) begin
      nRESET_BTN = ~nRESET_BTN;
      repeat (3) @(negedge CLK_24M);
    end
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL bounce_ignored: got %b required 11", {nRESETP, nRESET});
    end
    nRESET_BTN = 1'b0;
    repeat (9) @(negedge CLK_24M);
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b11) begin
      n_fail++;
      $display("FAIL btn_edge9: got %b required 11", {nRESETP, nRESET});
    end
    @(negedge CLK_24M);
    n_checks++;
    if ({nRESETP, nRESET, CAUSE} !== 4'b0001) begin
      n_fail++;
      $display("FAIL btn_edge10: got %b required 0001", {nRESETP, nRESET, CAUSE});
    end
    repeat (40) @(negedge CLK_24M);
    n_checks++;
    if ({nRESETP, nRESET} !== 2'b00) begin
      n_fail++;
      $display("FAIL btn_held: got %b required 00", {nRESETP, nRESET});
    end
    nRESET_BTN = 1'b1;
    measure_release(p, r);
    n_checks++;
    if (p !== 26 || r !== 30) begin
      n_fail++;
      $display("FAIL btn_release_edges: got %0d/%0d required 26/30", p, r);
    end
  endtask

  task automatic test_priority();
    int p, r;
    kick_pulse();
    n_checks++;
    if (WD_FIRED !== 1'b0) begin n_fail++; $display("FAIL prio_flag_cleared: got %b required 0", WD_FIRED); end
    frame_tick();
    frame_tick();
    nRESET_BTN = 1'b0;
    repeat (9) @(negedge CLK_24M);
    frame_tick();
    n_checks++;
    if ({nRESETP, nRESET, CAUSE, WD_FIRED} !== 5'b00010) begin
      n_fail++;
      $display("FAIL prio_btn_wins: got %b required 00010", {nRESETP, nRESET, CAUSE, WD_FIRED});
    end
    nRESET_BTN = 1'b1;
    measure_release(p, r);
    n_checks++;
    if (p !== 26 || r !== 30) begin
      n_fail++;
      $display("FAIL prio_release_edges: got %0d/%0d required 26/30", p, r);
    end
  endtask

  task automatic test_abort();
    int p, r;
    nRESET_BTN = 1'b0;
    repeat (10) @(negedge CLK_24M);
    nRESET_BTN = 1'b1;
    repeat (27) @(negedge CLK_24M);
    n_checks++;
    if ({nRESETP, nRESET, CAUSE} !== 4'b1001) begin
      n_fail++;
      $display("FAIL abort_in_stagger: got %b required 1001", {nRESETP, nRESET, CAUSE});
    end
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({nRESETP, nRESET, CAUSE, WD_FIRED} !== 5'b00000) begin
      n_fail++;
      $display("FAIL abort_async: got %b required 00000", {nRESETP, nRESET, CAUSE, WD_FIRED});
    end
    repeat (2) @(negedge CLK_24M);
    RESET = 1'b0;
    measure_release(p, r);
    n_checks++;
    if (p !== 16 || r !== 20) begin
      n_fail++;
      $display("FAIL abort_release_edges: got %0d/%0d required 16/20", p, r);
    end
  endtask

  initial begin
    test_reset();
    test_watchdog();
    test_kick();
    test_wd_enable();
    test_button_bounce();
    test_priority();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
